ifu_prefetch_q: RTL and testbench

Parametrised instruction-prefetch engine for the IFU. It sits between the PC/flush logic and the instruction-memory request/response channels. It keeps up to OUTS fetch requests in flight and buffers returned instructions in a DEPTH-entry queue toward the IR stage. It also discards stale responses after a flush, and reports misaligned targets and bus errors as tagged queue entries.

---
 rtl/ifu_prefetch_q_pkg.sv | 15 +
 rtl/ifu_prefetch_fifo.sv | 59 +++++
 rtl/ifu_prefetch_q.sv | 171 +++++++++++++++++
 tb/tb_ifu_prefetch_q.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_q_pkg.sv
// rtl/ifu_prefetch_q_pkg.sv - shared types and queue entry layout for the IFU prefetch queue
package ifu_prefetch_q_pkg;

  typedef enum logic [1:0] {
    IFQ_RUN  = 2'd0,
    IFQ_HALT = 2'd1,
    IFQ_STOP = 2'd2
  } ifq_state_e;

  // Queue entry is packed as {misalgn, buserr, pc, ir} with ir in the low bits.
  function automatic int ifq_entry_w(input int pc_w, input int instr_w);
    return instr_w + pc_w + 2;
  endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// rtl/ifu_prefetch_fifo.sv - synchronous FIFO with clear, used for the instruction queue and PC tags
module ifu_prefetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_wr_addr;

  function automatic logic [PTR_W-1:0] f_nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push coinciding with clear lands in slot 0 so it survives the clear.
  assign w_wr_addr = i_clr ? '0 : r_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_rd  <= '0;
      r_wr  <= i_push ? f_nxt('0) : '0;
      r_cnt <= i_push ? CNT_W'(1) : '0;
    end else begin
      if (i_push) r_wr <= f_nxt(r_wr);
      if (i_pop)  r_rd <= f_nxt(r_rd);
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_addr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/ifu_prefetch_q.sv
// rtl/ifu_prefetch_q.sv - IFU prefetch engine: bounded outstanding fetches feeding an instruction queue
module ifu_prefetch_q
  import ifu_prefetch_q_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int OUTS    = 2,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_rtvec,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_W-1:0]    ifu_req_pc,
  output logic               ifu_req_seq,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic               ifu_rsp_err,
  input  logic [INSTR_W-1:0] ifu_rsp_instr,
  output logic               ifu_o_valid,
  input  logic               ifu_o_ready,
  output logic [INSTR_W-1:0] ifu_o_ir,
  output logic [PC_W-1:0]    ifu_o_pc,
  output logic               ifu_o_buserr,
  output logic               ifu_o_misalgn,
  input  logic               pipe_flush_req,
  input  logic [PC_W-1:0]    pipe_flush_pc,
  output logic               pipe_flush_ack,
  input  logic               ifu_halt_req,
  output logic               ifu_halt_ack
);

  localparam int OW = $clog2(OUTS+1);
  localparam int QW = $clog2(DEPTH+1);
  localparam int EW = ifq_entry_w(PC_W, INSTR_W);
  localparam int SW = ((OW > QW) ? OW : QW) + 1;

  ifq_state_e      r_state;
  ifq_state_e      w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic            r_first;
  logic            r_pend;
  logic [OW-1:0]   r_discard;

  logic [OW-1:0]   w_inflight;
  logic [OW-1:0]   w_inflight_acc;
  logic [OW-1:0]   w_live;
  logic            w_tag_full;
  logic            w_tag_empty;
  logic [PC_W-1:0] w_tag_pc;
  logic [QW-1:0]   w_q_count;
  logic            w_q_full;
  logic            w_q_empty;
  logic [EW-1:0]   w_q_din;
  logic [EW-1:0]   w_q_dout;
  logic            w_q_push;
  logic            w_q_pop;
  logic            w_req_hs;
  logic            w_rsp_acc;
  logic            w_rsp_keep;
  logic            w_misalgn;
  logic            w_issue_ok;
  logic            w_pend_nxt;

  assign w_misalgn      = (pipe_flush_pc[1:0] != 2'b00);
  assign w_req_hs       = ifu_req_valid & ifu_req_ready;
  // A response with nothing in flight is a leftover from before reset and is ignored.
  assign w_rsp_acc      = ifu_rsp_valid & !w_tag_empty;
  assign w_rsp_keep     = w_rsp_acc & (r_discard == '0);
  assign w_live         = w_inflight - r_discard;
  assign w_inflight_acc = w_inflight + OW'(w_req_hs) - OW'(w_rsp_acc);
  assign w_pend_nxt     = ifu_req_valid & !ifu_req_ready;
  assign w_issue_ok     = (r_state == IFQ_RUN) & !ifu_halt_req & !w_tag_full & !w_q_full &
                          ((SW'(w_live) + SW'(w_q_count)) < SW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IFQ_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (pipe_flush_req) begin
      if (w_misalgn)         w_state_nxt = IFQ_STOP;
      else if (ifu_halt_req) w_state_nxt = IFQ_HALT;
      else                   w_state_nxt = IFQ_RUN;
    end else begin
      case (r_state)
        IFQ_RUN: begin
          if (w_rsp_keep & ifu_rsp_err)        w_state_nxt = IFQ_STOP;
          else if (ifu_halt_req & !w_pend_nxt) w_state_nxt = IFQ_HALT;
        end
        IFQ_HALT: begin
          if (w_rsp_keep & ifu_rsp_err) w_state_nxt = IFQ_STOP;
          else if (!ifu_halt_req)       w_state_nxt = IFQ_RUN;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // A request already presented stays up until accepted, even if halt arrives meanwhile.
  always_comb begin
    ifu_req_valid = !rst & (r_pend | w_issue_ok);
    ifu_halt_ack  = !rst & (r_state == IFQ_HALT) & w_tag_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= pc_rtvec;
      r_first   <= 1'b1;
      r_pend    <= 1'b0;
      r_discard <= '0;
    end else if (pipe_flush_req) begin
      r_pc      <= {pipe_flush_pc[PC_W-1:2], 2'b00};
      r_first   <= 1'b1;
      r_pend    <= 1'b0;
      r_discard <= w_inflight_acc;
    end else begin
      if (w_req_hs) begin
        r_pc    <= r_pc + PC_W'(4);
        r_first <= 1'b0;
      end
      r_pend <= w_pend_nxt;
      if (w_rsp_acc && (r_discard != '0)) r_discard <= r_discard - OW'(1);
    end
  end

  assign w_q_push = pipe_flush_req ? w_misalgn : w_rsp_keep;
  assign w_q_pop  = ifu_o_valid & ifu_o_ready & !pipe_flush_req;
  assign w_q_din  = pipe_flush_req ? {1'b1, 1'b0, pipe_flush_pc, {INSTR_W{1'b0}}}
                                   : {1'b0, ifu_rsp_err, w_tag_pc, ifu_rsp_instr};

  ifu_prefetch_fifo #(.WIDTH(PC_W), .DEPTH(OUTS)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_push  (w_req_hs),
    .i_din   (r_pc),
    .i_pop   (w_rsp_acc),
    .o_dout  (w_tag_pc),
    .o_count (w_inflight),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  ifu_prefetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (pipe_flush_req),
    .i_push  (w_q_push),
    .i_din   (w_q_din),
    .i_pop   (w_q_pop),
    .o_dout  (w_q_dout),
    .o_count (w_q_count),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  assign ifu_o_valid    = !w_q_empty;
  assign ifu_o_ir       = w_q_dout[INSTR_W-1:0] & {INSTR_W{ifu_o_valid}};
  assign ifu_o_pc       = w_q_dout[INSTR_W +: PC_W] & {PC_W{ifu_o_valid}};
  assign ifu_o_buserr   = w_q_dout[INSTR_W+PC_W] & ifu_o_valid;
  assign ifu_o_misalgn  = w_q_dout[EW-1] & ifu_o_valid;
  assign ifu_req_pc     = rst ? '0 : r_pc;
  assign ifu_req_seq    = !rst & !r_first;
  assign ifu_rsp_ready  = 1'b1;
  assign pipe_flush_ack = pipe_flush_req;

endmodule

// File: tb/tb_ifu_prefetch_q.sv
// tb/tb_ifu_prefetch_q.sv - directed self-checking bench for ifu_prefetch_q
module tb_ifu_prefetch_q;
  localparam int OUTS = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_rtvec;
  logic        ifu_req_valid, ifu_req_ready, ifu_req_seq;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_o_valid, ifu_o_ready, ifu_o_buserr, ifu_o_misalgn;
  logic [31:0] ifu_o_ir, ifu_o_pc;
  logic        pipe_flush_req, pipe_flush_ack;
  logic [31:0] pipe_flush_pc;
  logic        ifu_halt_req, ifu_halt_ack;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tb_out = 0;

  typedef struct { logic [31:0] pc; logic seq; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; logic be; logic ma; int cyc; } pop_t;
  req_t        req_log[$];
  pop_t        pop_log[$];
  logic [31:0] mem_q[$];
  logic [31:0] mem_p;
  logic        mem_hold = 1'b0;
  logic        keep_stale = 1'b0;
  logic        err_en = 1'b0;
  logic [31:0] err_pc = 32'h0;

  ifu_prefetch_q #(.PC_W(32), .INSTR_W(32), .OUTS(OUTS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_pc(ifu_req_pc), .ifu_req_seq(ifu_req_seq),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_err(ifu_rsp_err), .ifu_rsp_instr(ifu_rsp_instr),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir),
    .ifu_o_pc(ifu_o_pc), .ifu_o_buserr(ifu_o_buserr), .ifu_o_misalgn(ifu_o_misalgn),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc),
    .pipe_flush_ack(pipe_flush_ack),
    .ifu_halt_req(ifu_halt_req), .ifu_halt_ack(ifu_halt_ack)
  );

  always #5 clk = ~clk;

  // Monitor: log handshakes, queue fetch addresses, track outstanding requests.
  always @(negedge clk) begin
    cyc++;
    if (ifu_req_valid && ifu_req_ready) begin
      req_log.push_back('{ifu_req_pc, ifu_req_seq});
      mem_q.push_back(ifu_req_pc);
    end
    if (ifu_o_valid && ifu_o_ready)
      pop_log.push_back('{ifu_o_pc, ifu_o_ir, ifu_o_buserr, ifu_o_misalgn, cyc});
    if (rst) begin
      tb_out = 0;
      if (!keep_stale) mem_q.delete();
    end else begin
      if (ifu_rsp_valid && tb_out > 0) tb_out--;
      if (ifu_req_valid && ifu_req_ready) tb_out++;
      n_checks++;
      if (tb_out > OUTS) begin
        n_errors++;
        $display("FAIL outstanding: %0d in flight, limit %0d", tb_out, OUTS);
      end
    end
  end

  // Memory: one response per cycle, one cycle after the request.
  always @(posedge clk) begin
    #2;
    if (!mem_hold && mem_q.size() > 0 && !(rst && !keep_stale)) begin
      mem_p = mem_q.pop_front();
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = ~mem_p;
      ifu_rsp_err   = err_en && (mem_p == err_pc);
    end else begin
      ifu_rsp_valid = 1'b0;
      ifu_rsp_instr = 32'h0;
      ifu_rsp_err   = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [31:0] rtvec);
    rst = 1'b1;
    pc_rtvec = rtvec;
    pipe_flush_req = 1'b0;
    ifu_halt_req = 1'b0;
    ifu_req_ready = 1'b1;
    ifu_o_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    req_log.delete();
    pop_log.delete();
  endtask

  task automatic do_flush(input logic [31:0] fpc);
    pipe_flush_req = 1'b1;
    pipe_flush_pc = fpc;
    tick(1);
    pipe_flush_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pc_rtvec = 32'h8000_0000;
    pipe_flush_req = 1'b1;
    pipe_flush_pc = 32'h0;
    ifu_halt_req = 1'b0;
    ifu_req_ready = 1'b1;
    ifu_o_ready = 1'b1;
    tick(2);
    n_checks += 6;
    if (ifu_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_req_valid: got %b want 0", ifu_req_valid); end
    if (ifu_o_valid !== 1'b0) begin n_errors++; $display("FAIL rst_o_valid: got %b want 0", ifu_o_valid); end
    if (ifu_rsp_ready !== 1'b1) begin n_errors++; $display("FAIL rst_rsp_ready: got %b want 1", ifu_rsp_ready); end
    if (pipe_flush_ack !== 1'b1) begin n_errors++; $display("FAIL rst_flush_ack_hi: got %b want 1", pipe_flush_ack); end
    if (ifu_halt_ack !== 1'b0) begin n_errors++; $display("FAIL rst_halt_ack: got %b want 0", ifu_halt_ack); end
    if (ifu_req_pc !== 32'h0) begin n_errors++; $display("FAIL rst_req_pc: got %h want 0", ifu_req_pc); end
    pipe_flush_req = 1'b0;
    #1;
    n_checks++;
    if (pipe_flush_ack !== 1'b0) begin n_errors++; $display("FAIL rst_flush_ack_lo: got %b want 0", pipe_flush_ack); end
    rst = 1'b0;
    #1;
    n_checks += 3;
    if (ifu_req_valid !== 1'b1) begin n_errors++; $display("FAIL first_req_valid: got %b want 1", ifu_req_valid); end
    if (ifu_req_pc !== 32'h8000_0000) begin n_errors++; $display("FAIL first_req_pc: got %h want 80000000", ifu_req_pc); end
    if (ifu_req_seq !== 1'b0) begin n_errors++; $display("FAIL first_req_seq: got %b want 0", ifu_req_seq); end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    do_reset(32'h8000_0000);
    tick(8);
    n_checks++;
    if (req_log.size() < 3 || pop_log.size() < 3) begin
      n_errors++;
      $display("FAIL stream_count: got %0d reqs %0d pops want >=3", req_log.size(), pop_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = 32'h8000_0000 + 32'(4 * i);
        n_checks += 4;
        if (req_log[i].pc !== e) begin n_errors++; $display("FAIL stream_req_pc[%0d]: got %h want %h", i, req_log[i].pc, e); end
        if (req_log[i].seq !== (i != 0)) begin n_errors++; $display("FAIL stream_seq[%0d]: got %b want %b", i, req_log[i].seq, (i != 0)); end
        if (pop_log[i].pc !== e) begin n_errors++; $display("FAIL stream_o_pc[%0d]: got %h want %h", i, pop_log[i].pc, e); end
        if (pop_log[i].ir !== ~e) begin n_errors++; $display("FAIL stream_o_ir[%0d]: got %h want %h", i, pop_log[i].ir, ~e); end
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (pop_log[i].cyc !== pop_log[0].cyc + i) begin
          n_errors++;
          $display("FAIL stream_rate[%0d]: pop cycle %0d want %0d", i, pop_log[i].cyc, pop_log[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(32'h1000);
    ifu_o_ready = 1'b0;
    tick(12);
    n_checks += 3;
    if (req_log.size() != 4) begin n_errors++; $display("FAIL bp_req_count: got %0d want 4", req_log.size()); end
    if (ifu_req_valid !== 1'b0) begin n_errors++; $display("FAIL bp_req_valid: got %b want 0", ifu_req_valid); end
    if (ifu_o_valid !== 1'b1) begin n_errors++; $display("FAIL bp_o_valid: got %b want 1", ifu_o_valid); end
    ifu_o_ready = 1'b1;
    tick(1);
    ifu_o_ready = 1'b0;
    tick(6);
    n_checks += 2;
    if (req_log.size() != 5) begin
      n_errors++;
      $display("FAIL bp_refill_count: got %0d want 5", req_log.size());
    end else if (req_log[4].pc !== 32'h1010) begin
      n_errors++;
      $display("FAIL bp_refill_pc: got %h want 00001010", req_log[4].pc);
    end
    if (pop_log.size() != 1 || pop_log[0].pc !== 32'h1000) begin
      n_errors++;
      $display("FAIL bp_pop: got %0d pops want single pop of pc 00001000", pop_log.size());
    end
  endtask

  task automatic test_flush_stale;
    do_reset(32'h2000);
    mem_hold = 1'b1;
    tick(4);
    n_checks++;
    if (req_log.size() != 2) begin n_errors++; $display("FAIL fs_inflight: got %0d reqs want 2", req_log.size()); end
    do_flush(32'h100);
    n_checks++;
    if (ifu_o_valid !== 1'b0) begin n_errors++; $display("FAIL fs_q_empty: got %b want 0", ifu_o_valid); end
    req_log.delete();
    pop_log.delete();
    mem_hold = 1'b0;
    tick(8);
    n_checks += 2;
    if (req_log.size() < 1) begin
      n_errors++;
      $display("FAIL fs_req: got no request want pc 00000100");
    end else if (req_log[0].pc !== 32'h100 || req_log[0].seq !== 1'b0) begin
      n_errors++;
      $display("FAIL fs_req: got pc %h seq %b want 00000100 seq 0", req_log[0].pc, req_log[0].seq);
    end
    if (pop_log.size() < 1) begin
      n_errors++;
      $display("FAIL fs_pop: got no pop want pc 00000100");
    end else if (pop_log[0].pc !== 32'h100 || pop_log[0].ir !== ~32'h100) begin
      n_errors++;
      $display("FAIL fs_pop: got pc %h ir %h want 00000100 %h", pop_log[0].pc, pop_log[0].ir, ~32'h100);
    end
  endtask

  task automatic test_misalign;
    do_reset(32'h3000);
    tick(4);
    ifu_o_ready = 1'b0;
    do_flush(32'h102);
    req_log.delete();
    n_checks += 4;
    if (ifu_o_valid !== 1'b1) begin n_errors++; $display("FAIL ma_valid: got %b want 1", ifu_o_valid); end
    if (ifu_o_pc !== 32'h102) begin n_errors++; $display("FAIL ma_pc: got %h want 00000102", ifu_o_pc); end
    if (ifu_o_ir !== 32'h0) begin n_errors++; $display("FAIL ma_ir: got %h want 0", ifu_o_ir); end
    if (ifu_o_misalgn !== 1'b1 || ifu_o_buserr !== 1'b0) begin
      n_errors++;
      $display("FAIL ma_flags: got misalgn %b buserr %b want 1 0", ifu_o_misalgn, ifu_o_buserr);
    end
    tick(6);
    n_checks += 2;
    if (req_log.size() != 0) begin n_errors++; $display("FAIL ma_stopped: got %0d reqs want 0", req_log.size()); end
    if (ifu_o_valid !== 1'b1) begin n_errors++; $display("FAIL ma_held: got %b want 1", ifu_o_valid); end
    ifu_o_ready = 1'b1;
    tick(1);
    ifu_o_ready = 1'b0;
    n_checks++;
    if (ifu_o_valid !== 1'b0) begin n_errors++; $display("FAIL ma_single: got %b want 0", ifu_o_valid); end
    ifu_o_ready = 1'b1;
    do_flush(32'h200);
    tick(6);
    n_checks++;
    if (req_log.size() < 1) begin
      n_errors++;
      $display("FAIL ma_resume: got no request want pc 00000200");
    end else if (req_log[0].pc !== 32'h200 || req_log[0].seq !== 1'b0) begin
      n_errors++;
      $display("FAIL ma_resume: got pc %h seq %b want 00000200 seq 0", req_log[0].pc, req_log[0].seq);
    end
  endtask

  task automatic test_buserr;
    do_reset(32'h8);
    err_en = 1'b1;
    err_pc = 32'h10;
    tick(10);
    n_checks += 2;
    if (req_log.size() != 4) begin
      n_errors++;
      $display("FAIL be_req_count: got %0d want 4", req_log.size());
    end else if (req_log[3].pc !== 32'h14) begin
      n_errors++;
      $display("FAIL be_last_req: got %h want 00000014", req_log[3].pc);
    end
    if (pop_log.size() < 3) begin
      n_errors++;
      $display("FAIL be_pops: got %0d want >=3", pop_log.size());
    end else begin
      n_checks += 2;
      if (pop_log[2].pc !== 32'h10 || pop_log[2].be !== 1'b1 || pop_log[2].ma !== 1'b0 || pop_log[2].ir !== ~32'h10) begin
        n_errors++;
        $display("FAIL be_entry: got pc %h be %b ma %b ir %h want 00000010 1 0 %h",
                 pop_log[2].pc, pop_log[2].be, pop_log[2].ma, pop_log[2].ir, ~32'h10);
      end
      if (pop_log[1].be !== 1'b0) begin n_errors++; $display("FAIL be_clean: got %b want 0", pop_log[1].be); end
    end
    err_en = 1'b0;
    do_flush(32'h40);
    req_log.delete();
    pop_log.delete();
    tick(5);
    n_checks += 2;
    if (req_log.size() < 1 || req_log[0].pc !== 32'h40 || req_log[0].seq !== 1'b0) begin
      n_errors++;
      $display("FAIL be_resume_req: got %0d reqs want first pc 00000040 seq 0", req_log.size());
    end
    if (pop_log.size() < 1 || pop_log[0].pc !== 32'h40 || pop_log[0].be !== 1'b0) begin
      n_errors++;
      $display("FAIL be_resume_pop: got %0d pops want first pc 00000040 clean", pop_log.size());
    end
  endtask

  task automatic test_halt;
    do_reset(32'h500);
    mem_hold = 1'b1;
    tick(3);
    n_checks++;
    if (req_log.size() != 2) begin n_errors++; $display("FAIL h_inflight: got %0d want 2", req_log.size()); end
    ifu_halt_req = 1'b1;
    tick(2);
    n_checks++;
    if (ifu_halt_ack !== 1'b0) begin n_errors++; $display("FAIL h_ack_busy: got %b want 0", ifu_halt_ack); end
    mem_hold = 1'b0;
    tick(1);
    n_checks++;
    if (ifu_halt_ack !== 1'b0) begin n_errors++; $display("FAIL h_ack_early: got %b want 0", ifu_halt_ack); end
    tick(1);
    n_checks++;
    if (ifu_halt_ack !== 1'b1) begin n_errors++; $display("FAIL h_ack_rise: got %b want 1", ifu_halt_ack); end
    tick(3);
    n_checks++;
    if (req_log.size() != 2) begin n_errors++; $display("FAIL h_no_issue: got %0d want 2", req_log.size()); end
    ifu_halt_req = 1'b0;
    req_log.delete();
    tick(3);
    n_checks++;
    if (req_log.size() < 1 || req_log[0].pc !== 32'h508 || req_log[0].seq !== 1'b1) begin
      n_errors++;
      $display("FAIL h_resume: got %0d reqs want first pc 00000508 seq 1", req_log.size());
    end
  endtask

  task automatic test_reset_mid;
    do_reset(32'h600);
    mem_hold = 1'b1;
    tick(3);
    ifu_halt_req = 1'b1;
    keep_stale = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    pop_log.delete();
    req_log.delete();
    mem_hold = 1'b0;
    tick(4);
    n_checks += 3;
    if (ifu_o_valid !== 1'b0 || pop_log.size() != 0) begin
      n_errors++;
      $display("FAIL rm_stale: got o_valid %b pops %0d want 0 0", ifu_o_valid, pop_log.size());
    end
    if (ifu_halt_ack !== 1'b1) begin n_errors++; $display("FAIL rm_halt_ack: got %b want 1", ifu_halt_ack); end
    if (req_log.size() != 0) begin n_errors++; $display("FAIL rm_halted: got %0d reqs want 0", req_log.size()); end
    keep_stale = 1'b0;
    ifu_halt_req = 1'b0;
    tick(6);
    n_checks += 2;
    if (req_log.size() < 1 || req_log[0].pc !== 32'h600 || req_log[0].seq !== 1'b0) begin
      n_errors++;
      $display("FAIL rm_req: got %0d reqs want first pc 00000600 seq 0", req_log.size());
    end
    if (pop_log.size() < 1 || pop_log[0].pc !== 32'h600 || pop_log[0].ir !== ~32'h600) begin
      n_errors++;
      $display("FAIL rm_pop: got %0d pops want first pc 00000600 ir %h", pop_log.size(), ~32'h600);
    end
  endtask

  initial begin
    rst = 1'b1;
    pc_rtvec = 32'h0;
    ifu_req_ready = 1'b1;
    ifu_o_ready = 1'b1;
    pipe_flush_req = 1'b0;
    pipe_flush_pc = 32'h0;
    ifu_halt_req = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err = 1'b0;
    ifu_rsp_instr = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_stale();
    test_misalign();
    test_buserr();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
